ex_mem_pipe: RTL and testbench
==============================

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of data, immediate and operand fields.
REQ-002 SHALL have parameter ADDR_W, default 5, width of destination register address.
REQ-003 SHALL have port Clk  input  1  single clock, all state rising-edge.
REQ-004 SHALL have port Rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port InValid  input  1  EX presents a valid instruction bundle.
REQ-006 SHALL have port InReady  output  1  stage accepts bundle this cycle.
REQ-007 SHALL have port OutValid  output  1  MEM-side bundle valid.
REQ-008 SHALL have port OutReady  input  1  MEM consumes bundle this cycle.
REQ-009 SHALL have port Flush  input  1  discard all held bundles.
REQ-010 SHALL have port Occupancy  output  2  number of held bundles, 0..2.
REQ-011 SHALL have payload inputs RdWriteDataIn DATA_W, RdAddrIn ADDR_W, RdWriteEnableIn 1, ImmIn DATA_W, OpCodeIn 7, Funct3In 3, Rs1ReadDataIn DATA_W, Rs2ReadDataIn DATA_W.
REQ-012 SHALL have matching payload outputs with suffix Out and identical widths.

Function
REQ-013 Transfer in SHALL occur when InValid and InReady are both high at a rising edge; transfer out when OutValid and OutReady are both high.
REQ-014 Payload outputs SHALL come from the head entry only; bundle latency SHALL be exactly 1 cycle when the stage is empty.
REQ-015 RdWriteEnableOut SHALL equal stored enable AND OutValid; never high while OutValid is low.
REQ-016 States: EMPTY (Occupancy 0), HEAD (1), FULL (2, skid build only).
REQ-017 EMPTY: transfer in -> HEAD.
REQ-018 HEAD: in and out together -> HEAD with new payload; out only -> EMPTY; in only -> FULL (skid build) or not possible (base build).
REQ-019 FULL: out -> HEAD with skid entry moved to head; no transfer in is possible in FULL.
REQ-020 Payload SHALL remain stable while OutValid is high and OutReady is low.
REQ-021 Flush SHALL override all transfers: next state EMPTY, Occupancy 0, OutValid 0; InReady SHALL be low during a Flush cycle; an incoming bundle in that cycle SHALL be dropped.
REQ-022 Payload registers SHALL not be required to clear on Flush; only valid state SHALL clear.
REQ-023 Occupancy SHALL never exceed 1 in the base build and 2 in the skid build.

Reset
REQ-024 On Rst low, asynchronously: state EMPTY, OutValid 0, Occupancy 0, RdWriteEnableOut 0, all payload outputs 0.
REQ-025 Reset asserted mid-transfer SHALL discard every held bundle; first acceptance SHALL be possible on the first rising edge after Rst deasserts.
REQ-026 InReady SHALL be low while Rst is low.

Configuration
REQ-027 Macro EX_MEM_SKID_EN SHALL select the skid buffer.
REQ-028 Defined: second entry present; InReady is a registered signal equal to NOT FULL; sustained 1 bundle/cycle with no combinational InReady-from-OutReady path.
REQ-029 Undefined: single entry; InReady = NOT OutValid OR OutReady (combinational); FULL state absent; Occupancy bit 1 tied 0.

Verification
REQ-030 Reset then InValid=1, RdWriteDataIn=0x1234, RdAddrIn=5, RdWriteEnableIn=1, OutReady=1 -> next cycle OutValid=1, RdWriteDataOut=0x1234, RdAddrOut=5, RdWriteEnableOut=1.
REQ-031 Stream 8 bundles ImmIn=1..8 with OutReady=1 continuously -> 8 consecutive OutValid cycles, ImmOut 1..8 in order, no gaps.
REQ-032 Skid build: OutReady=0, offer bundles A=0xA, B=0xB, C=0xC -> A, B accepted, Occupancy=2, InReady=0, C held; OutReady=1 -> out A, B, C in order.
REQ-033 Occupancy=2, Flush=1 with InValid=1 -> next cycle OutValid=0, Occupancy=0, RdWriteEnableOut=0, flushed-cycle bundle never appears.
REQ-034 Rst pulled low mid-stream with Occupancy=1 -> immediately OutValid=0, all payload outputs 0; after release, next bundle emerges 1 cycle after acceptance.
REQ-035 Base build, OutValid=1, OutReady=0 for 5 cycles -> InReady=0, payload outputs unchanged for all 5 cycles.

Source files
------------

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe -- EX->MEM pipeline register stage with valid/ready handshake.
//
// Holds the execute-stage result bundle for the memory stage. A bundle is
// accepted when InValid and InReady are both high at a rising edge of Clk,
// and leaves when OutValid and OutReady are both high. Payload outputs always
// come from the head entry.
//
// Build option (macro EX_MEM_SKID_EN):
//   undefined : single entry; InReady = !OutValid | OutReady (combinational).
//   defined   : head plus skid entry; InReady is registered (not FULL), so
//               there is no combinational path from OutReady to InReady and
//               the stage still sustains one bundle per cycle.
//
// Ports:
//   Clk, Rst                 clock (rising edge), async active-low reset
//   InValid / InReady        upstream handshake
//   OutValid / OutReady      downstream handshake
//   Flush                    drops every held bundle and the incoming one
//   Occupancy                number of held bundles (0..2)
//   *In / *Out               instruction bundle payload
//
// state | meaning
// ------+----------------------------------------------
// EMPTY | nothing held, OutValid low
// HEAD  | one bundle held in the head entry
// FULL  | head and skid entries both held (skid build)
module ex_mem_pipe #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              InValid,
   output logic              InReady,
   output logic              OutValid,
   input  logic              OutReady,
   input  logic              Flush,
   output logic [1:0]        Occupancy,
   input  logic [DATA_W-1:0] RdWriteDataIn,
   input  logic [ADDR_W-1:0] RdAddrIn,
   input  logic              RdWriteEnableIn,
   input  logic [DATA_W-1:0] ImmIn,
   input  logic [6:0]        OpCodeIn,
   input  logic [2:0]        Funct3In,
   input  logic [DATA_W-1:0] Rs1ReadDataIn,
   input  logic [DATA_W-1:0] Rs2ReadDataIn,
   output logic [DATA_W-1:0] RdWriteDataOut,
   output logic [ADDR_W-1:0] RdAddrOut,
   output logic              RdWriteEnableOut,
   output logic [DATA_W-1:0] ImmOut,
   output logic [6:0]        OpCodeOut,
   output logic [2:0]        Funct3Out,
   output logic [DATA_W-1:0] Rs1ReadDataOut,
   output logic [DATA_W-1:0] Rs2ReadDataOut
);

   localparam int PAY_W = 4*DATA_W + ADDR_W + 1 + 7 + 3;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HEAD  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t             state;
   state_t             nextState;
   logic [PAY_W-1:0]   inPayload;
   logic [PAY_W-1:0]   headQ;
   logic               headWe;
   logic               inFire;
   logic               outFire;
   logic               loadHeadFromIn;
`ifdef EX_MEM_SKID_EN
   logic [PAY_W-1:0]   skidQ;
   logic               loadSkid;
   logic               loadHeadFromSkid;
   logic               inReadyQ;
`endif

   assign inPayload = {RdWriteDataIn, RdAddrIn, RdWriteEnableIn, ImmIn,
                       OpCodeIn, Funct3In, Rs1ReadDataIn, Rs2ReadDataIn};

   assign inFire  = InValid & InReady;
   assign outFire = OutValid & OutReady;

   always_comb begin
      nextState      = state;
      loadHeadFromIn = 1'b0;
`ifdef EX_MEM_SKID_EN
      loadSkid         = 1'b0;
      loadHeadFromSkid = 1'b0;
`endif
      if (Flush) begin
         // Only valid state is cleared; stale payload is harmless.
         nextState = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (inFire) begin
                  nextState      = HEAD;
                  loadHeadFromIn = 1'b1;
               end
            end
            HEAD: begin
               if (inFire && outFire) begin
                  loadHeadFromIn = 1'b1;
               end else if (outFire) begin
                  nextState = EMPTY;
               end
`ifdef EX_MEM_SKID_EN
               else if (inFire) begin
                  nextState = FULL;
                  loadSkid  = 1'b1;
               end
`endif
            end
`ifdef EX_MEM_SKID_EN
            FULL: begin
               // InReady is low in FULL, so only a departure can happen.
               if (outFire) begin
                  nextState        = HEAD;
                  loadHeadFromSkid = 1'b1;
               end
            end
`endif
            default: nextState = EMPTY;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= EMPTY;
      end else begin
         state <= nextState;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         headQ <= '0;
      end else if (loadHeadFromIn) begin
         headQ <= inPayload;
      end
`ifdef EX_MEM_SKID_EN
      else if (loadHeadFromSkid) begin
         headQ <= skidQ;
      end
`endif
   end

`ifdef EX_MEM_SKID_EN
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         skidQ <= '0;
      end else if (loadSkid) begin
         skidQ <= inPayload;
      end
   end

   // Reset to 1 so the first edge after reset release can accept.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         inReadyQ <= 1'b1;
      end else begin
         inReadyQ <= (nextState != FULL);
      end
   end

   assign InReady   = inReadyQ & Rst & ~Flush;
   assign Occupancy = (state == FULL) ? 2'd2 :
                      (state == HEAD) ? 2'd1 : 2'd0;
`else
   assign InReady   = Rst & ~Flush & (~OutValid | OutReady);
   assign Occupancy = {1'b0, (state == HEAD)};
`endif

   assign OutValid = (state != EMPTY);

   assign {RdWriteDataOut, RdAddrOut, headWe, ImmOut,
           OpCodeOut, Funct3Out, Rs1ReadDataOut, Rs2ReadDataOut} = headQ;

   assign RdWriteEnableOut = headWe & OutValid;

endmodule

// File: tb/tb_ex_mem_pipe.sv
module tb_ex_mem_pipe;

   localparam int DW = 64;
   localparam int AW = 5;

   typedef struct packed {
      logic [DW-1:0] wd;
      logic [AW-1:0] addr;
      logic          we;
      logic [DW-1:0] imm;
      logic [6:0]    op;
      logic [2:0]    f3;
      logic [DW-1:0] rs1;
      logic [DW-1:0] rs2;
   } bundle_t;

   logic Clk = 1'b0;
   logic Rst;
   logic InValid = 1'b0;
   logic OutReady = 1'b0;
   logic Flush = 1'b0;
   bundle_t drv = '0;

   logic          InReady;
   logic          OutValid;
   logic [1:0]    Occupancy;
   logic [DW-1:0] RdWriteDataOut;
   logic [AW-1:0] RdAddrOut;
   logic          RdWriteEnableOut;
   logic [DW-1:0] ImmOut;
   logic [6:0]    OpCodeOut;
   logic [2:0]    Funct3Out;
   logic [DW-1:0] Rs1ReadDataOut;
   logic [DW-1:0] Rs2ReadDataOut;

   ex_mem_pipe #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .Clk(Clk), .Rst(Rst),
      .InValid(InValid), .InReady(InReady),
      .OutValid(OutValid), .OutReady(OutReady),
      .Flush(Flush), .Occupancy(Occupancy),
      .RdWriteDataIn(drv.wd), .RdAddrIn(drv.addr), .RdWriteEnableIn(drv.we),
      .ImmIn(drv.imm), .OpCodeIn(drv.op), .Funct3In(drv.f3),
      .Rs1ReadDataIn(drv.rs1), .Rs2ReadDataIn(drv.rs2),
      .RdWriteDataOut(RdWriteDataOut), .RdAddrOut(RdAddrOut),
      .RdWriteEnableOut(RdWriteEnableOut), .ImmOut(ImmOut),
      .OpCodeOut(OpCodeOut), .Funct3Out(Funct3Out),
      .Rs1ReadDataOut(Rs1ReadDataOut), .Rs2ReadDataOut(Rs2ReadDataOut)
   );

   always #5 Clk = ~Clk;

   int passCnt = 0;
   int totalCnt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: a FIFO of held bundles with the stage's capacity.
   bundle_t q[$];
   bit payloadZero = 1'b1;

   function automatic bit modelReady();
      if (!Rst || Flush) return 1'b0;
`ifdef EX_MEM_SKID_EN
      return q.size() < 2;
`else
      return (q.size() == 0) || OutReady;
`endif
   endfunction

   always @(negedge Rst) begin
      q.delete();
      payloadZero = 1'b1;
   end

   always @(posedge Clk) begin
      bit inAcc;
      bit outAcc;
      if (Rst === 1'b1) begin
         inAcc  = InValid && modelReady();
         outAcc = (q.size() > 0) && OutReady;
         if (Flush) begin
            q.delete();
         end else begin
            if (outAcc) void'(q.pop_front());
            if (inAcc) begin
               q.push_back(drv);
               payloadZero = 1'b0;
            end
         end
      end
   end

   always @(negedge Clk) begin
      bit v;
      v = (q.size() > 0);
      chk("OutValid", OutValid, v);
      chk("Occupancy", Occupancy, 64'(q.size()));
      chk("InReady", InReady, modelReady());
      if (v) begin
         chk("RdWriteDataOut", RdWriteDataOut, q[0].wd);
         chk("RdAddrOut", RdAddrOut, q[0].addr);
         chk("RdWriteEnableOut", RdWriteEnableOut, q[0].we);
         chk("ImmOut", ImmOut, q[0].imm);
         chk("OpCodeOut", OpCodeOut, q[0].op);
         chk("Funct3Out", Funct3Out, q[0].f3);
         chk("Rs1ReadDataOut", Rs1ReadDataOut, q[0].rs1);
         chk("Rs2ReadDataOut", Rs2ReadDataOut, q[0].rs2);
      end else begin
         chk("RdWriteEnableOut_idle", RdWriteEnableOut, 0);
         if (payloadZero) begin
            chk("ZeroWd", RdWriteDataOut, 0);
            chk("ZeroImm", ImmOut, 0);
            chk("ZeroRs", Rs1ReadDataOut | Rs2ReadDataOut, 0);
            chk("ZeroCtl", {RdAddrOut, OpCodeOut, Funct3Out}, 0);
         end
      end
   end

   function automatic bundle_t rndBundle();
      bundle_t b;
      b.wd   = {$urandom, $urandom};
      b.addr = AW'($urandom);
      b.we   = 1'($urandom);
      b.imm  = {$urandom, $urandom};
      b.op   = 7'($urandom);
      b.f3   = 3'($urandom);
      b.rs1  = {$urandom, $urandom};
      b.rs2  = {$urandom, $urandom};
      return b;
   endfunction

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      int got[$];
      int firstC;
      int lastC;
      logic expHoldRdy;

      Rst = 1'b1;
      #2 Rst = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_OutValid", OutValid, 0);
      chk("rst_Occupancy", Occupancy, 0);
      chk("rst_InReady", InReady, 0);
      chk("rst_RdWriteData", RdWriteDataOut, 0);

      // Single bundle, first edge after reset release.
      Rst = 1'b1;
      drv = '0;
      drv.wd = 64'h1234; drv.addr = 5; drv.we = 1'b1;
      InValid = 1'b1; OutReady = 1'b1;
      #1 chk("first_InReady", InReady, 1);
      cyc();
      InValid = 1'b0;
      chk("single_OutValid", OutValid, 1);
      chk("single_RdWriteData", RdWriteDataOut, 64'h1234);
      chk("single_RdAddr", RdAddrOut, 5);
      chk("single_RdWe", RdWriteEnableOut, 1);
      cyc();

      // Back-to-back stream of 8 bundles.
      firstC = -1; lastC = -1;
      for (int c = 0; c < 11; c++) begin
         if (c < 8) begin
            drv = rndBundle();
            drv.imm = 64'(c + 1);
            InValid = 1'b1;
         end else begin
            InValid = 1'b0;
         end
         cyc();
         if (OutValid) begin
            got.push_back(int'(ImmOut));
            if (firstC < 0) firstC = c;
            lastC = c;
         end
      end
      chk("stream_count", 64'(got.size()), 8);
      chk("stream_nogap", 64'(lastC - firstC), 7);
      for (int i = 0; i < got.size(); i++) chk("stream_order", 64'(got[i]), 64'(i + 1));

      // Stall with OutReady low for 5 cycles: payload must hold.
      OutReady = 1'b0;
      drv = rndBundle();
      drv.wd = 64'hCAFE; drv.imm = 64'h51;
      InValid = 1'b1;
      cyc();
      InValid = 1'b0;
`ifdef EX_MEM_SKID_EN
      expHoldRdy = 1'b1;
`else
      expHoldRdy = 1'b0;
`endif
      for (int i = 0; i < 5; i++) begin
         chk("hold_InReady", InReady, expHoldRdy);
         chk("hold_OutValid", OutValid, 1);
         chk("hold_RdWriteData", RdWriteDataOut, 64'hCAFE);
         chk("hold_Imm", ImmOut, 64'h51);
         cyc();
      end

`ifdef EX_MEM_SKID_EN
      drv = rndBundle();
      InValid = 1'b1;
      cyc();
      chk("prefl_Occupancy", Occupancy, 2);
`endif
      // Flush with a bundle offered in the same cycle.
      Flush = 1'b1;
      drv = rndBundle();
      drv.imm = 64'hD; drv.we = 1'b1;
      InValid = 1'b1;
      #1 chk("flush_InReady", InReady, 0);
      cyc();
      Flush = 1'b0; InValid = 1'b0;
      chk("flush_OutValid", OutValid, 0);
      chk("flush_Occupancy", Occupancy, 0);
      chk("flush_RdWe", RdWriteEnableOut, 0);
      OutReady = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc();
         chk("flush_gone", OutValid, 0);
      end

`ifdef EX_MEM_SKID_EN
      // Skid fill: A and B held, C waits until space frees.
      OutReady = 1'b0;
      drv = rndBundle(); drv.imm = 64'hA; InValid = 1'b1;
      cyc();
      drv = rndBundle(); drv.imm = 64'hB;
      cyc();
      drv = rndBundle(); drv.imm = 64'hC;
      chk("skid_Occupancy", Occupancy, 2);
      chk("skid_InReady", InReady, 0);
      chk("skid_head", ImmOut, 64'hA);
      cyc();
      chk("skid_Cheld", Occupancy, 2);
      OutReady = 1'b1;
      cyc();
      chk("skid_outB", ImmOut, 64'hB);
      cyc();
      InValid = 1'b0;
      chk("skid_outC", ImmOut, 64'hC);
      cyc();
      chk("skid_empty", OutValid, 0);
`endif

      // Reset asserted while one bundle is held.
      OutReady = 1'b0;
      drv = rndBundle(); drv.wd = 64'h55; drv.imm = 64'h77; drv.we = 1'b1;
      InValid = 1'b1;
      cyc();
      InValid = 1'b0;
      chk("prerst_Occupancy", Occupancy, 1);
      @(posedge Clk);
      #3 Rst = 1'b0;
      #1;
      chk("midrst_OutValid", OutValid, 0);
      chk("midrst_Occupancy", Occupancy, 0);
      chk("midrst_RdWriteData", RdWriteDataOut, 0);
      chk("midrst_Imm", ImmOut, 0);
      chk("midrst_RdWe", RdWriteEnableOut, 0);
      chk("midrst_InReady", InReady, 0);
      cyc();
      Rst = 1'b1;
      drv = rndBundle(); drv.imm = 64'h99;
      InValid = 1'b1; OutReady = 1'b1;
      cyc();
      InValid = 1'b0;
      chk("postrst_OutValid", OutValid, 1);
      chk("postrst_Imm", ImmOut, 64'h99);
      cyc();

      // Randomized traffic checked by the model each cycle.
      for (int i = 0; i < 600; i++) begin
         drv      = rndBundle();
         InValid  = ($urandom_range(0, 9) < 7);
         OutReady = ($urandom_range(0, 9) < 6);
         Flush    = ($urandom_range(0, 19) == 0);
         cyc();
      end
      Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
      repeat (3) cyc();

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
